array_fifo_ctrl: RTL



---
 rtl/array_fifo_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/array_fifo_ctrl.sv
// 130-entry FIFO controller around a single-port 128x108 masked array with 1-cycle read latency.
// A 2-entry output buffer absorbs read latency; every item passes through the array.
`timescale 1ns/1ps

module array_fifo_ctrl #(
    parameter  int unsigned DEPTH = 128,
    parameter  int unsigned WIDTH = 108,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 3)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic [CW-1:0]    count,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_en,
    output logic             mem_wmode,
    output logic [3:0]       mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      ram_cnt;
    logic             rd_pend;
    logic [1:0]       ob_cnt;
    logic [WIDTH-1:0] ob_head;
    logic [WIDTH-1:0] ob_tail;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic ram_empty;
    logic ram_full;
    logic credit_ok;
    logic read_urgent;
    logic wr_fire;
    logic rd_fire;
    logic push;
    logic pop;

    always_comb begin
        ram_empty   = (ram_cnt == '0);
        ram_full    = (ram_cnt == (AW+1)'(DEPTH));
        credit_ok   = (ob_cnt + {1'b0, rd_pend}) < 2'd2;
        read_urgent = !ram_empty && (ob_cnt == 2'd0) && !rd_pend;

        // reset_n gates the handshakes so they read 0 for the whole reset window
        enq_ready = reset_n && !ram_full && !read_urgent && !flush;
        wr_fire   = enq_valid && enq_ready;
        rd_fire   = reset_n && !ram_empty && credit_ok && !wr_fire && !flush;

        deq_valid = reset_n && (ob_cnt != 2'd0);
        deq_data  = ob_head;
        pop       = deq_valid && deq_ready && !flush;
        push      = rd_pend && !flush;

        count = CW'(ram_cnt) + CW'(rd_pend) + CW'(ob_cnt);
    end

    always_comb begin
        mem_en    = wr_fire || rd_fire;
        mem_wmode = wr_fire;
        mem_wmask = wr_fire ? 4'hF : 4'h0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (wr_fire) begin
            mem_addr  = wptr;
            mem_wdata = enq_data;
        end else if (rd_fire) begin
            mem_addr  = rptr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            ob_cnt  <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            ob_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wptr    <= wptr + 1'b1;
                ram_cnt <= ram_cnt + 1'b1;
            end else if (rd_fire) begin
                rptr    <= rptr + 1'b1;
                ram_cnt <= ram_cnt - 1'b1;
            end
            rd_pend <= rd_fire;
            if (push && !pop) begin
                ob_cnt <= ob_cnt + 2'd1;
            end else if (pop && !push) begin
                ob_cnt <= ob_cnt - 2'd1;
            end
        end
    end

    // Credit accounting keeps ob_cnt <= 1 whenever a capture lands, so the
    // pop+push case only ever refills the head.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ob_head <= '0;
            ob_tail <= '0;
        end else if (pop) begin
            if (ob_cnt == 2'd2) begin
                ob_head <= ob_tail;
            end else if (push) begin
                ob_head <= mem_rdata;
            end
        end else if (push) begin
            if (ob_cnt == 2'd0) begin
                ob_head <= mem_rdata;
            end else begin
                ob_tail <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (mem_en) begin
                addr_q <= mem_addr;
            end
            if (wr_fire) begin
                wdata_q <= enq_data;
            end
        end
    end

endmodule
